pc_seq_ctrl: RTL
================

# pc_seq_ctrl

Program-counter sequencing controller for the 5-stage pipeline. It drives the PC register's load enable, synchronous clear and next-PC value, and the IF/ID and ID/EX flush/enable controls. It arbitrates between sequential fetch, jump redirects from ID, branch redirects from EX, load-use stalls and instruction-memory wait states. It also sequences boot and halt/resume and keeps a saturating bubble counter for performance monitoring.

## Interface
- RESET_VEC, 16'h0000, PC value loaded on boot and present on pc_next during BOOT
- BOOT_CYCLES, 2, cycles pc_clr is held high after reset release (≥1)
- PC_STEP, 16'h0001, sequential increment (word-addressed 16-bit instructions)

- clk  in  1  rising-edge clock; sole clock
- clr_n  in  1  asynchronous, active-low reset
- pc_cur  in  16  current PC from PC register output
- imem_ready  in  1  instruction memory returns valid fetch this cycle
- stall_req  in  1  load-use hazard detected in ID
- jmp  in  1  jump decoded in ID
- jmp_target  in  16  jump destination
- br_taken  in  1  branch resolved taken in EX
- br_target  in  16  branch destination
- halt  in  1  halt instruction reached ID
- resume  in  1  single-cycle resume pulse
- pc_en  out  1  PC register load enable
- pc_clr  out  1  PC register synchronous clear
- pc_next  out  16  PC register data input
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID bubble insert
- id_ex_flush  out  1  ID/EX bubble insert
- halted  out  1  high while in HALT
- bubble_cnt  out  16  saturating count of stall/flush/wait cycles

## Operation
- States: BOOT, RUN, WAIT, HALT. Reset (clr_n=0) → BOOT, boot counter = BOOT_CYCLES, pending-redirect register cleared, bubble_cnt = 0.
- BOOT: pc_clr=1, pc_en=0, pc_next=RESET_VEC, if_id_flush=1, id_ex_flush=1, if_id_en=0. Counter decrements each cycle; at 1 → RUN.
- RUN priority (highest first): br_taken > jmp > halt > stall_req > !imem_ready > sequential.
  - br_taken: pc_next=br_target, pc_en=imem_ready, if_id_flush=1, id_ex_flush=1; coincident jmp, stall_req and halt ignored (younger instructions).
  - jmp: pc_next=jmp_target, pc_en=imem_ready, if_id_flush=1; coincident stall_req ignored.
  - halt (no redirect): pc_en=0, if_id_flush=1 → HALT.
  - stall_req: pc_en=0, if_id_en=0, id_ex_flush=1.
  - !imem_ready: pc_en=0, if_id_flush=1 → WAIT.
  - else: pc_next=pc_cur+PC_STEP (mod 2^16, FFFF wraps to 0000), pc_en=1, if_id_en=1.
- Redirect with imem_ready=0: target latched in pending register, pc_en=0 → WAIT.
- WAIT: pc_en=0, if_id_flush=1. A new br_taken overwrites pending target (and still flushes ID/EX); jmp overwrites only if no pending branch. On imem_ready=1: pc_en=1, pc_next = pending target if valid else pc_cur+PC_STEP; pending cleared → RUN.
- HALT: pc_en=0, if_id_flush=1, halted=1. resume → RUN with next-cycle normal fetch from pc_cur. br_taken in HALT (older branch) redirects as in RUN and leaves HALT.
- if_id_en=1 and all flushes 0 unless stated. pc_clr=0 outside BOOT.
- bubble_cnt increments in every non-BOOT cycle where pc_en=0 or any flush is high; saturates at 16'hFFFF.

## Timing
- Reset values: pc_en=0, pc_clr=1, pc_next=RESET_VEC, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=0, bubble_cnt=0.
- pc_en, pc_next, and flush/enables are combinational from state, registers and inputs; the PC updates on the same edge a redirect is sampled (0-cycle redirect latency, 2 bubbles for branch, 1 for jump).
- First sequential PC update occurs on the edge after BOOT exits: PC = RESET_VEC+PC_STEP.
- clr_n assertion mid-WAIT/HALT discards pending redirect immediately (async).

## Test plan
- Reset, BOOT_CYCLES=2, imem_ready=1 -> pc_clr high 2 cycles, then PC 0000,0001,0002…; bubble_cnt stays 0 after BOOT.
- PC at 0x0010, br_taken with br_target=0x0040 and jmp=1 same cycle -> next PC 0x0040, if_id_flush=id_ex_flush=1 one cycle, bubble_cnt +1.
- stall_req high 2 cycles at PC 0x0005 -> PC holds 0x0005, if_id_en=0, id_ex_flush=1 both cycles, then 0x0006.
- jmp to 0x0100 with imem_ready=0 for 3 cycles -> PC frozen, WAIT, then PC=0x0100 on ready edge; br_taken to 0x0200 during WAIT -> final PC 0x0200.
- PC=0xFFFF sequential -> wraps to 0x0000.
- halt -> halted=1, PC frozen 5 cycles; resume pulse -> fetch continues; clr_n low mid-HALT -> BOOT, halted=0, bubble_cnt=0.

Source files
------------

// File: rtl/pc_seq_ctrl_if.sv
// Bundle between the PC sequencing controller and the pipeline it steers.
// slave  : controller side (samples hazards/redirects, drives PC and stage controls)
// master : pipeline side (drives hazards/redirects/current PC, observes controls)
interface pc_seq_ctrl_if;
    logic [15:0] pc_cur;
    logic        imem_ready;
    logic        stall_req;
    logic        jmp;
    logic [15:0] jmp_target;
    logic        br_taken;
    logic [15:0] br_target;
    logic        halt;
    logic        resume;
    logic        pc_en;
    logic        pc_clr;
    logic [15:0] pc_next;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        halted;
    logic [15:0] bubble_cnt;

    modport slave (
        input  pc_cur, imem_ready, stall_req, jmp, jmp_target,
               br_taken, br_target, halt, resume,
        output pc_en, pc_clr, pc_next, if_id_en, if_id_flush,
               id_ex_flush, halted, bubble_cnt
    );

    modport master (
        output pc_cur, imem_ready, stall_req, jmp, jmp_target,
               br_taken, br_target, halt, resume,
        input  pc_en, pc_clr, pc_next, if_id_en, if_id_flush,
               id_ex_flush, halted, bubble_cnt
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller for the 5-stage pipeline: arbitrates sequential
// fetch, ID jumps, EX branches, load-use stalls and imem wait states, and
// sequences boot and halt/resume. Keeps a saturating bubble counter.
// Ports: clk (rising edge), clr_n (async active-low reset),
//        bus (pc_seq_ctrl_if.slave) carrying all hazard, redirect and PC controls.
module pc_seq_ctrl #(
    parameter logic [15:0] RESET_VEC   = 16'h0000,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter logic [15:0] PC_STEP     = 16'h0001
) (
    input  logic          clk,
    input  logic          clr_n,
    pc_seq_ctrl_if.slave  bus
);

    localparam int unsigned PC_W   = 16;
    localparam int unsigned BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_WAIT, ST_HALT} state_t;

    state_t            r_state;
    logic [BOOT_W-1:0] r_boot_cnt;
    logic              r_pend_vld;
    logic              r_pend_br;
    logic [PC_W-1:0]   r_pend_tgt;
    logic [PC_W-1:0]   r_bubble_cnt;

    state_t            w_state_nxt;
    logic              w_pend_vld_nxt;
    logic              w_pend_br_nxt;
    logic [PC_W-1:0]   w_pend_tgt_nxt;
    logic              w_pc_en;
    logic              w_pc_clr;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_if_id_en;
    logic              w_if_id_flush;
    logic              w_id_ex_flush;
    logic [PC_W-1:0]   w_seq_pc;
    logic              w_bubble;

    assign w_seq_pc = bus.pc_cur + PC_STEP;

    // State, boot counter, pending redirect and bubble counter
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state      <= ST_BOOT;
            r_boot_cnt   <= BOOT_W'(BOOT_CYCLES);
            r_pend_vld   <= 1'b0;
            r_pend_br    <= 1'b0;
            r_pend_tgt   <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_br  <= w_pend_br_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            if (r_state == ST_BOOT && r_boot_cnt != '0)
                r_boot_cnt <= r_boot_cnt - BOOT_W'(1);
            if (w_bubble && r_bubble_cnt != {PC_W{1'b1}})
                r_bubble_cnt <= r_bubble_cnt + PC_W'(1);
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_br_nxt  = r_pend_br;
        w_pend_tgt_nxt = r_pend_tgt;
        w_pc_en        = 1'b0;
        w_pc_clr       = 1'b0;
        w_pc_next      = w_seq_pc;
        w_if_id_en     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_pc_clr      = 1'b1;
                w_pc_next     = RESET_VEC;
                w_if_id_en    = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                if (r_boot_cnt <= BOOT_W'(1))
                    w_state_nxt = ST_RUN;
            end

            ST_RUN, ST_HALT: begin
                // An EX branch is older than anything in ID, so it wins even in HALT
                if (bus.br_taken) begin
                    w_pc_next     = bus.br_target;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    if (bus.imem_ready) begin
                        w_pc_en     = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_br_nxt  = 1'b1;
                        w_pend_tgt_nxt = bus.br_target;
                        w_state_nxt    = ST_WAIT;
                    end
                end else if (r_state == ST_HALT) begin
                    w_if_id_flush = 1'b1;
                    if (bus.resume)
                        w_state_nxt = ST_RUN;
                end else if (bus.jmp) begin
                    w_pc_next     = bus.jmp_target;
                    w_if_id_flush = 1'b1;
                    if (bus.imem_ready) begin
                        w_pc_en = 1'b1;
                    end else begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_br_nxt  = 1'b0;
                        w_pend_tgt_nxt = bus.jmp_target;
                        w_state_nxt    = ST_WAIT;
                    end
                end else if (bus.halt) begin
                    w_if_id_flush = 1'b1;
                    w_state_nxt   = ST_HALT;
                end else if (bus.stall_req) begin
                    w_if_id_en    = 1'b0;
                    w_id_ex_flush = 1'b1;
                end else if (!bus.imem_ready) begin
                    w_if_id_flush = 1'b1;
                    w_state_nxt   = ST_WAIT;
                end else begin
                    w_pc_en = 1'b1;
                end
            end

            ST_WAIT: begin
                w_if_id_flush = 1'b1;
                // A pending branch is older than any jump and must not be overwritten by one
                if (bus.br_taken) begin
                    w_id_ex_flush  = 1'b1;
                    w_pend_vld_nxt = 1'b1;
                    w_pend_br_nxt  = 1'b1;
                    w_pend_tgt_nxt = bus.br_target;
                end else if (bus.jmp && !(r_pend_vld && r_pend_br)) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_br_nxt  = 1'b0;
                    w_pend_tgt_nxt = bus.jmp_target;
                end
                if (bus.imem_ready) begin
                    w_pc_en   = 1'b1;
                    w_pc_next = w_pend_vld_nxt ? w_pend_tgt_nxt : w_seq_pc;
                    // Without a redirect the stalled fetch is now valid and enters IF/ID
                    if (!w_pend_vld_nxt)
                        w_if_id_flush = 1'b0;
                    w_pend_vld_nxt = 1'b0;
                    w_pend_br_nxt  = 1'b0;
                    w_state_nxt    = ST_RUN;
                end
            end

            default: w_state_nxt = ST_BOOT;
        endcase
    end

    assign w_bubble = (r_state != ST_BOOT) &&
                      (!w_pc_en || w_if_id_flush || w_id_ex_flush);

    assign bus.pc_en       = w_pc_en;
    assign bus.pc_clr      = w_pc_clr;
    assign bus.pc_next     = w_pc_next;
    assign bus.if_id_en    = w_if_id_en;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.halted      = (r_state == ST_HALT);
    assign bus.bubble_cnt  = r_bubble_cnt;

endmodule
